// File: rtl/stack_ctrl_pkg.sv
// Shared types and sizes for the stack controller: opcodes, FSM states,
// stack depth and data width.
package stack_ctrl_pkg;

    localparam int DATA_W      = 8;
    localparam int STACK_DEPTH = 32;
    localparam int DEPTH_W     = 6;   // holds 0..STACK_DEPTH inclusive

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_TOP  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP1  = 3'd1,
        CAP1  = 3'd2,
        POP2  = 3'd3,
        CAP2  = 3'd4,
        PUSHR = 3'd5,
        DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/result handshake between a command issuer (master) and the
// stack controller (slave).
interface stack_ctrl_if;
    import stack_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;
    logic [DATA_W-1:0] cmd_imm;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_imm,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm,
        output cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/stack_ctrl_alu.sv
// Combinational ALU for the binary/unary stack ops. A is the first value
// popped (old top), B the second; all results wrap modulo 2^DATA_W.
module stack_ctrl_alu
    import stack_ctrl_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // B is the deeper operand, so B-A matches "second minus top"
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/stack_controller.sv
// Stack controller: sequences push/pop/top strobes to an external stack
// with registered read data and reports one completion per command.
// Optional feature: define STACK_CTRL_DEPTH_CHECK_EN to add an occupancy
// counter that rejects commands the stack cannot satisfy.
module stack_controller
    import stack_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    stack_ctrl_if.slave       bus,
    output logic [DATA_W-1:0] stk_data,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_tos,
    input  logic [DATA_W-1:0] stk_res
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] push_val;
    logic              accept;
    logic              reject;
    logic              err_q;

    // gated by rst so ready is low for the whole reset, high right after
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign push_val      = (op_q == OP_PUSH) ? imm_q : alu_y;

`ifdef STACK_CTRL_DEPTH_CHECK_EN
    logic [DEPTH_W-1:0] depth_q;

    // occupancy follows the strobes actually issued to the stack
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            depth_q <= '0;
        else if (stk_push)
            depth_q <= depth_q + DEPTH_W'(1);
        else if (stk_pop)
            depth_q <= depth_q - DEPTH_W'(1);
    end

    // judge the offered command against the current occupancy
    always_comb begin
        reject = 1'b0;
        case (bus.cmd_op)
            OP_PUSH:                reject = (depth_q == DEPTH_W'(STACK_DEPTH));
            OP_POP, OP_TOP, OP_NOT: reject = (depth_q == '0);
            OP_ADD, OP_SUB, OP_AND: reject = (depth_q < DEPTH_W'(2));
            default:                reject = 1'b0;
        endcase
    end

    // keep the verdict for the completion cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= reject;
    end
`else
    assign reject = 1'b0;
    assign err_q  = 1'b0;
`endif

    stack_ctrl_alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // FSM state register; reset abandons any command in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // command and operand capture; datapath only, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.cmd_op;
            imm_q <= bus.cmd_imm;
        end
        if (state_q == CAP1)
            a_q <= stk_res;
        if (state_q == CAP2)
            b_q <= stk_res;
    end

    // next-state sequencing per opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject || bus.cmd_op == OP_NOP)
                        state_d = DONE;
                    else if (bus.cmd_op == OP_PUSH)
                        state_d = PUSHR;
                    else
                        state_d = POP1;
                end
            end
            POP1: state_d = CAP1;
            CAP1: begin
                if (op_q == OP_NOT)
                    state_d = PUSHR;
                else if (op_q == OP_POP || op_q == OP_TOP)
                    state_d = IDLE;
                else
                    state_d = POP2;
            end
            POP2:    state_d = CAP2;
            CAP2:    state_d = PUSHR;
            PUSHR:   state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // strobes and completion decoded from the current state
    always_comb begin
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_tos       = 1'b0;
        stk_data      = '0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_err   = 1'b0;
        case (state_q)
            POP1: begin
                if (op_q == OP_TOP)
                    stk_tos = 1'b1;
                else
                    stk_pop = 1'b1;
            end
            CAP1: begin
                if (op_q == OP_POP || op_q == OP_TOP) begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = stk_res;
                end
            end
            POP2: stk_pop = 1'b1;
            PUSHR: begin
                stk_push      = 1'b1;
                stk_data      = push_val;
                bus.res_valid = 1'b1;
                bus.res_data  = push_val;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                bus.res_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule
